pb_field_encoder: RTL and testbench
===================================

Name: pb_field_encoder

Overview:
Registered protobuf field encoder for the serializer datapath.
- Forms the field tag from a field ID and wire type, and varint-encodes it into up to 5 bytes (field_header function).
- Varint-encodes a 64-bit scalar value into up to 10 bytes (varint_ser function).
- Reports the byte count of each encoding and sits between the field walker and the output byte packer.

Parameters:
- None. All widths are fixed by the protobuf wire format.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  field_id, field_type and value are valid this cycle
- field_id  input  29  protobuf field number
- field_type  input  5  wire type; only values 0..5 are legal
- value  input  64  scalar value to varint-encode
- out_valid  output  1  registered outputs are valid
- hdr_bytes  output  40  tag varint; byte k at [8k+7:8k]; byte 0 is first on the wire
- hdr_len  output  3  number of valid tag bytes, 1..5
- val_bytes  output  80  value varint; byte k at [8k+7:8k]; byte 0 is first on the wire
- val_len  output  4  number of valid value bytes, 1..10
- type_err  output  1  field_type captured with this result was greater than 5

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0 immediately, including out_valid.
  - Deasserting rst_n mid-stream discards any in-flight result.
  - The first capture happens on the first clk rising edge with rst_n high and in_valid high.
- Latency: exactly 1 cycle.
  - A rising edge with in_valid=1 registers the results.
  - out_valid=1 in the following cycle.
- A rising edge with in_valid=0 sets out_valid to 0. The data outputs hold their last values.
- There is no backpressure; a new input is accepted every cycle.
- Tag: tag[31:0] = {field_id, field_type[2:0]}, i.e. field_id*8 + wire type.
- type_err = (field_type > 5). The tag is still encoded from field_type[2:0]; field_type[4:3] are ignored for the tag.
- Varint rule (both encoders):
  - Split the operand into 7-bit groups, least significant first.
  - n = index of the highest nonzero group + 1; n = 1 when the operand is 0.
  - Output byte k (k < n) = {continuation, group k}, where continuation = 1 for k < n-1 and 0 for k = n-1.
  - Output bytes k >= n are 0x00.
- Length limits:
  - A 32-bit tag gives at most 5 bytes; the last byte is at most 0x0F.
  - A 64-bit value gives at most 10 bytes; the last byte is at most 0x01.
- Boundary cases:
  - Operand 0 gives 1 byte, 0x00.
  - Operand 127 gives 1 byte, 0x7F.
  - Operand 128 gives 2 bytes, 0x80 then 0x01.
- Implementation: purely combinational encode (priority detection of the top nonzero group) feeding a single register stage.

Test Plan:
- value=150 with in_valid pulsed for 1 cycle -> next cycle out_valid=1, val_bytes=0x...0196 (bytes 0x96, 0x01), val_len=2; the cycle after, out_valid=0.
- field_id=150, field_type=3 -> tag 1203; hdr_bytes=0x00000009B3, hdr_len=2, type_err=0. Then field_type=1 on the next cycle -> hdr_bytes=0x00000009B1, hdr_len=2.
- value=0, field_id=0, field_type=0 -> val_bytes=0, val_len=1, hdr_bytes=0, hdr_len=1.
- value=2^64-1 -> bytes 0..8 = 0xFF, byte 9 = 0x01, val_len=10. value=127 -> 0x7F, len 1. value=128 -> 0x80, 0x01, len 2.
- field_id=2^29-1, field_type=0 -> hdr_bytes bytes F8, FF, FF, FF, 0F; hdr_len=5. field_type=6 -> type_err=1, tag encoded with wire type 6.
- Back-to-back inputs on consecutive cycles -> one result per cycle, in order. Asserting rst_n low mid-stream -> all outputs go to 0 without waiting for a clock edge; out_valid stays 0 until a new in_valid.

Source files
------------

// File: rtl/pb_field_encoder.sv
// Protobuf field encoder: builds the field tag varint (field_id, wire type)
// and the value varint, each with its byte count, behind one register stage.
//
// Handshake: in_valid qualifies field_id/field_type/value on a rising edge;
// there is no ready, so a new input is taken every cycle. out_valid marks the
// registered result one cycle later. While in_valid is low, out_valid drops
// and the data outputs keep their last captured values.
module pb_field_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [28:0] field_id,
  input  logic [4:0]  field_type,
  input  logic [63:0] value,
  output logic        out_valid,
  output logic [39:0] hdr_bytes,
  output logic [2:0]  hdr_len,
  output logic [79:0] val_bytes,
  output logic [3:0]  val_len,
  output logic        type_err
);

  // Operands zero-extended to a whole number of 7-bit groups.
  logic [34:0] w_tag_ext;
  logic [69:0] w_val_ext;
  logic [39:0] w_hdr_bytes;
  logic [2:0]  w_hdr_len;
  logic [79:0] w_val_bytes;
  logic [3:0]  w_val_len;
  logic        w_type_err;

  logic        r_out_valid;
  logic [39:0] r_hdr_bytes;
  logic [2:0]  r_hdr_len;
  logic [79:0] r_val_bytes;
  logic [3:0]  r_val_len;
  logic        r_type_err;

  // The tag only ever uses the low three wire-type bits; the upper two only
  // feed the error flag.
  assign w_tag_ext  = {3'b000, field_id, field_type[2:0]};
  assign w_val_ext  = {6'd0, value};
  assign w_type_err = (field_type > 5'd5);

  // Tag varint: highest nonzero group sets the length, then set continuation
  // bits on every byte below it and zero the bytes above it.
  always_comb begin
    w_hdr_len   = 3'd1;
    w_hdr_bytes = '0;
    for (int k = 1; k < 5; k++) begin
      if (w_tag_ext[7*k +: 7] != 7'd0) w_hdr_len = 3'(k + 1);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < int'(w_hdr_len)) begin
        w_hdr_bytes[8*k +: 8] = {(k + 1 < int'(w_hdr_len)), w_tag_ext[7*k +: 7]};
      end
    end
  end

  // Value varint: same rule over ten 7-bit groups.
  always_comb begin
    w_val_len   = 4'd1;
    w_val_bytes = '0;
    for (int k = 1; k < 10; k++) begin
      if (w_val_ext[7*k +: 7] != 7'd0) w_val_len = 4'(k + 1);
    end
    for (int k = 0; k < 10; k++) begin
      if (k < int'(w_val_len)) begin
        w_val_bytes[8*k +: 8] = {(k + 1 < int'(w_val_len)), w_val_ext[7*k +: 7]};
      end
    end
  end

  // Result register: capture on in_valid, hold data otherwise, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_hdr_bytes <= '0;
      r_hdr_len   <= '0;
      r_val_bytes <= '0;
      r_val_len   <= '0;
      r_type_err  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_hdr_bytes <= w_hdr_bytes;
        r_hdr_len   <= w_hdr_len;
        r_val_bytes <= w_val_bytes;
        r_val_len   <= w_val_len;
        r_type_err  <= w_type_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign hdr_bytes = r_hdr_bytes;
  assign hdr_len   = r_hdr_len;
  assign val_bytes = r_val_bytes;
  assign val_len   = r_val_len;
  assign type_err  = r_type_err;

endmodule

// File: tb/tb_pb_field_encoder.sv
// Bench for pb_field_encoder: directed cases from the protobuf varint rules
// plus randomized back-to-back traffic checked against a byte-loop model.
module tb_pb_field_encoder;

  localparam int W = 128;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [28:0] field_id;
  logic [4:0]  field_type;
  logic [63:0] value;
  logic        out_valid;
  logic [39:0] hdr_bytes;
  logic [2:0]  hdr_len;
  logic [79:0] val_bytes;
  logic [3:0]  val_len;
  logic        type_err;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  pb_field_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .field_id   (field_id),
    .field_type (field_type),
    .value      (value),
    .out_valid  (out_valid),
    .hdr_bytes  (hdr_bytes),
    .hdr_len    (hdr_len),
    .val_bytes  (val_bytes),
    .val_len    (val_len),
    .type_err   (type_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Classic varint loop: emit low 7 bits, shift, flag continuation if more remain.
  function automatic void varint(input logic [63:0] v_in, output logic [79:0] b, output int n);
    logic [63:0] v;
    logic [7:0]  x;
    v = v_in;
    b = '0;
    n = 0;
    do begin
      x = {1'b0, v[6:0]};
      v = v >> 7;
      if (v != 64'd0) x[7] = 1'b1;
      b[8*n +: 8] = x;
      n++;
    end while (v != 64'd0);
  endfunction

  // Packed as {type_err, hdr_len, hdr_bytes, val_len, val_bytes}.
  function automatic logic [W-1:0] model(input logic [28:0] id, input logic [4:0] ty,
                                         input logic [63:0] v);
    logic [79:0] hb, vb;
    int          hn, vn;
    logic [63:0] tag;
    tag = 64'(id) * 64'd8 + 64'(ty % 5'd8);
    varint(tag, hb, hn);
    varint(v, vb, vn);
    return {(ty > 5'd5), 3'(hn), hb[39:0], 4'(vn), vb};
  endfunction

  function automatic logic [W-1:0] actual();
    return {type_err, hdr_len, hdr_bytes, val_len, val_bytes};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [28:0] id, input logic [4:0] ty, input logic [63:0] v);
    in_valid   = 1'b1;
    field_id   = id;
    field_type = ty;
    value      = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; field_id = '0; field_type = '0; value = '0;
    #2;
    total++;
    if (out_valid !== 1'b0 || actual() !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b data=%h want valid=0 data=0", out_valid, actual());
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_value_150();
    drive(29'd0, 5'd0, 64'd150);
    total++;
    if (out_valid !== 1'b1 || val_bytes !== 80'h0196 || val_len !== 4'd2) begin
      bad++;
      $display("FAIL value_150: got v=%b b=%h l=%0d want v=1 b=0196 l=2", out_valid, val_bytes, val_len);
    end
    idle();
    total++;
    if (out_valid !== 1'b0 || val_bytes !== 80'h0196 || val_len !== 4'd2) begin
      bad++;
      $display("FAIL value_150_hold: got v=%b b=%h l=%0d want v=0 b=0196 l=2", out_valid, val_bytes, val_len);
    end
  endtask

  task automatic test_header();
    drive(29'd150, 5'd3, 64'd0);
    total++;
    if (hdr_bytes !== 40'h09B3 || hdr_len !== 3'd2 || type_err !== 1'b0) begin
      bad++;
      $display("FAIL hdr_150_3: got b=%h l=%0d e=%b want b=09b3 l=2 e=0", hdr_bytes, hdr_len, type_err);
    end
    drive(29'd150, 5'd1, 64'd0);
    total++;
    if (hdr_bytes !== 40'h09B1 || hdr_len !== 3'd2 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hdr_150_1: got b=%h l=%0d v=%b want b=09b1 l=2 v=1", hdr_bytes, hdr_len, out_valid);
    end
    idle();
  endtask

  task automatic test_zero();
    drive(29'd0, 5'd0, 64'd0);
    total++;
    if (val_bytes !== 80'h0 || val_len !== 4'd1 || hdr_bytes !== 40'h0 || hdr_len !== 3'd1) begin
      bad++;
      $display("FAIL zero: got vb=%h vl=%0d hb=%h hl=%0d want 0/1/0/1", val_bytes, val_len, hdr_bytes, hdr_len);
    end
    idle();
  endtask

  task automatic test_value_bounds();
    logic [63:0] vals [3];
    logic [79:0] eb   [3];
    logic [3:0]  el   [3];
    vals[0] = 64'hFFFF_FFFF_FFFF_FFFF; eb[0] = 80'h01FF_FFFF_FFFF_FFFF_FFFF; el[0] = 4'd10;
    vals[1] = 64'd127;                 eb[1] = 80'h7F;                     el[1] = 4'd1;
    vals[2] = 64'd128;                 eb[2] = 80'h0180;                   el[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      drive(29'd1, 5'd0, vals[i]);
      total++;
      if (val_bytes !== eb[i] || val_len !== el[i]) begin
        bad++;
        $display("FAIL value_bound_%0d: got b=%h l=%0d want b=%h l=%0d", i, val_bytes, val_len, eb[i], el[i]);
      end
    end
    idle();
  endtask

  task automatic test_header_bounds();
    drive(29'h1FFF_FFFF, 5'd0, 64'd0);
    total++;
    if (hdr_bytes !== 40'h0F_FFFF_FFF8 || hdr_len !== 3'd5 || type_err !== 1'b0) begin
      bad++;
      $display("FAIL hdr_max_id: got b=%h l=%0d e=%b want b=0ffffffff8 l=5 e=0", hdr_bytes, hdr_len, type_err);
    end
    drive(29'd5, 5'd6, 64'd0);
    total++;
    if (hdr_bytes !== 40'h2E || hdr_len !== 3'd1 || type_err !== 1'b1) begin
      bad++;
      $display("FAIL hdr_type6: got b=%h l=%0d e=%b want b=2e l=1 e=1", hdr_bytes, hdr_len, type_err);
    end
    drive(29'd5, 5'd13, 64'd0);
    total++;
    if (hdr_bytes !== 40'h2D || type_err !== 1'b1) begin
      bad++;
      $display("FAIL hdr_type13: got b=%h e=%b want b=2d e=1", hdr_bytes, type_err);
    end
    drive(29'd5, 5'd5, 64'd0);
    total++;
    if (hdr_bytes !== 40'h2D || type_err !== 1'b0) begin
      bad++;
      $display("FAIL hdr_type5: got b=%h e=%b want b=2d e=0", hdr_bytes, type_err);
    end
    idle();
  endtask

  // Random back-to-back stream with occasional idle cycles; results in order.
  task automatic test_back_to_back();
    logic [28:0]  id;
    logic [4:0]   ty;
    logic [63:0]  v;
    logic [W-1:0] last;
    logic [W-1:0] exp;
    last = actual();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
        total++;
        if (out_valid !== 1'b0 || actual() !== last) begin
          bad++;
          $display("FAIL rand_idle_%0d: got v=%b d=%h want v=0 d=%h", i, out_valid, actual(), last);
        end
      end else begin
        id = 29'($urandom()) >> $urandom_range(0, 28);
        ty = 5'($urandom_range(0, 31));
        v  = {32'($urandom()), 32'($urandom())} >> $urandom_range(0, 63);
        exp_q.push_back(model(id, ty, v));
        drive(id, ty, v);
        exp = exp_q.pop_front();
        last = exp;
        total++;
        if (out_valid !== 1'b1 || actual() !== exp) begin
          bad++;
          $display("FAIL rand_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, actual(), exp);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    drive(29'd150, 5'd3, 64'd150);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || actual() !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%b d=%h want v=0 d=0", out_valid, actual());
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || actual() !== '0) begin
      bad++;
      $display("FAIL reset_held: got v=%b d=%h want v=0 d=0", out_valid, actual());
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || actual() !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: got v=%b d=%h want v=0 d=0", out_valid, actual());
    end
    drive(29'd150, 5'd3, 64'd150);
    total++;
    if (out_valid !== 1'b1 || actual() !== model(29'd150, 5'd3, 64'd150)) begin
      bad++;
      $display("FAIL post_reset_capture: got v=%b d=%h want v=1 d=%h", out_valid, actual(),
               model(29'd150, 5'd3, 64'd150));
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_value_150();
    test_header();
    test_zero();
    test_value_bounds();
    test_header_bounds();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
